// File: rtl/main_memory.sv
// Slow single-port backing store behind the cache: one word read/write per
// request, completed after a fixed latency with a one-cycle MReady pulse.
module main_memory #(
  parameter int ADDR_W    = 8,
  parameter int LATENCY   = 4,
  parameter     INIT_FILE = ""
) (
  input  logic        CLK,
  input  logic        Reset,
  input  logic        MEn,
  input  logic [31:0] MAddr,
  input  logic        MWE,
  input  logic [31:0] MWD,
  output logic        MReady,
  output logic [31:0] MRD
);

  localparam int         DEPTH    = 1 << ADDR_W;
  localparam logic [3:0] CNT_INIT = 4'(LATENCY - 1);

  typedef enum logic [1:0] {
    IDLE,
    BUSY,
    DONE
  } state_t;

  state_t              state;
  logic [3:0]          cnt;
  logic [ADDR_W-1:0]   idx;
  logic                we;
  logic [31:0]         wd;
  logic [31:0]         mem [0:DEPTH-1];
  logic                fire;

  // Byte offset and bits above the word index are don't-care (addresses wrap).
  logic unused_addr_bits;
  assign unused_addr_bits = ^{MAddr[31:ADDR_W+2], MAddr[1:0]};

  assign fire = (state == BUSY) && (cnt == '0);

  // LATENCY=1 needs no special path: cnt starts at 0, so BUSY completes on the
  // very next edge.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      state  <= IDLE;
      cnt    <= '0;
      MReady <= 1'b0;
      MRD    <= '0;
      idx    <= '0;
      we     <= 1'b0;
      wd     <= '0;
    end else begin
      case (state)
        IDLE: begin
          MReady <= 1'b0;
          if (MEn) begin
            idx   <= MAddr[ADDR_W+1:2];
            we    <= MWE;
            wd    <= MWD;
            cnt   <= CNT_INIT;
            state <= BUSY;
          end
        end
        BUSY: begin
          if (cnt != '0) begin
            cnt <= cnt - 4'd1;
          end else begin
            if (!we) begin
              MRD <= mem[idx];
            end
            MReady <= 1'b1;
            state  <= DONE;
          end
        end
        DONE: begin
          MReady <= 1'b0;
          state  <= IDLE;
        end
        default: begin
          MReady <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

  // Storage is not reset; an asynchronous reset forces IDLE, so an aborted
  // write never reaches this port.
  always_ff @(posedge CLK) begin
    if (fire && we) begin
      mem[idx] <= wd;
    end
  end

endmodule
